// File: rtl/mem_stage_if.sv
// Data bus bundle between the MEM stage and the data memory slave.
// The stage drives a registered request; the slave answers with data and an ack.
interface mem_stage_if;
    logic        dbus_req_o;
    logic        dbus_we_o;
    logic [31:0] dbus_addr_o;
    logic [3:0]  dbus_be_o;
    logic [31:0] dbus_wdata_o;
    logic [31:0] dbus_rdata_i;
    logic        dbus_ack_i;

    modport master (
        output dbus_req_o, dbus_we_o, dbus_addr_o,
        output dbus_be_o, dbus_wdata_o,
        input  dbus_rdata_i, dbus_ack_i
    );

    modport slave (
        input  dbus_req_o, dbus_we_o, dbus_addr_o,
        input  dbus_be_o, dbus_wdata_o,
        output dbus_rdata_i, dbus_ack_i
    );
endinterface

// File: rtl/mem_stage.sv
// MEM pipeline stage: ALU pass-through, load/store bus transactions,
// big-endian lane steering, sign/zero extension and alignment check.
module mem_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush_i,
    input  logic [3:0]  mem_op_i,
    input  logic [31:0] mem_ramaddr_i,
    input  logic [31:0] mem_store_data_i,
    input  logic        mem_wreg_en_i,
    input  logic [4:0]  mem_wreg_addr_i,
    input  logic [31:0] mem_alu_i,
    mem_stage_if.master dbus,
    output logic        stallreq_o,
    output logic        misalign_o,
    output logic        wb_wreg_en_o,
    output logic [4:0]  wb_wreg_addr_o,
    output logic [31:0] wb_wdata_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_n;
    logic        r_req;
    logic        r_we;
    logic [31:0] r_addr;
    logic [3:0]  r_be;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_flushed;

    logic        w_load;
    logic        w_store;
    logic        w_signed;
    logic [1:0]  w_size;
    logic        w_aligned;
    logic        w_mem;
    logic        w_start;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;

    // w_size: 0 byte, 1 halfword, 2 word
    always_comb begin
        w_load   = 1'b0;
        w_store  = 1'b0;
        w_signed = 1'b0;
        w_size   = 2'd0;
        case (mem_op_i)
            4'd1: begin w_load = 1'b1; w_signed = 1'b1; end
            4'd2: begin w_load = 1'b1; end
            4'd3: begin w_load = 1'b1; w_signed = 1'b1; w_size = 2'd1; end
            4'd4: begin w_load = 1'b1; w_size = 2'd1; end
            4'd5: begin w_load = 1'b1; w_size = 2'd2; end
            4'd6: begin w_store = 1'b1; end
            4'd7: begin w_store = 1'b1; w_size = 2'd1; end
            4'd8: begin w_store = 1'b1; w_size = 2'd2; end
            default: ;
        endcase
    end

    assign w_mem     = w_load | w_store;
    assign w_aligned = (w_size == 2'd0)
                     | ((w_size == 2'd1) & ~mem_ramaddr_i[0])
                     | ((w_size == 2'd2) & (mem_ramaddr_i[1:0] == 2'b00));
    assign w_start   = w_mem & w_aligned & ~flush_i;

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = mem_store_data_i;
        case (w_size)
            2'd0: begin
                w_be    = 4'b1000 >> mem_ramaddr_i[1:0];
                w_wdata = {4{mem_store_data_i[7:0]}};
            end
            2'd1: begin
                w_be    = mem_ramaddr_i[1] ? 4'b0011 : 4'b1100;
                w_wdata = {2{mem_store_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    // Byte offset 0 is the most significant lane
    always_comb begin
        w_byte = r_rdata[31:24];
        case (mem_ramaddr_i[1:0])
            2'd1: w_byte = r_rdata[23:16];
            2'd2: w_byte = r_rdata[15:8];
            2'd3: w_byte = r_rdata[7:0];
            default: ;
        endcase
    end

    assign w_half = mem_ramaddr_i[1] ? r_rdata[15:0] : r_rdata[31:16];

    always_comb begin
        w_load_val = r_rdata;
        case (w_size)
            2'd0: w_load_val = {{24{w_signed & w_byte[7]}}, w_byte};
            2'd1: w_load_val = {{16{w_signed & w_half[15]}}, w_half};
            default: ;
        endcase
    end

    always_comb begin
        w_state_n      = r_state;
        stallreq_o     = 1'b0;
        misalign_o     = 1'b0;
        wb_wreg_en_o   = 1'b0;
        wb_wreg_addr_o = mem_wreg_addr_i;
        wb_wdata_o     = mem_alu_i;
        case (r_state)
            IDLE: begin
                if (flush_i) begin
                    wb_wreg_en_o = 1'b0;
                end else if (!w_mem) begin
                    wb_wreg_en_o = mem_wreg_en_i;
                end else if (!w_aligned) begin
                    misalign_o = 1'b1;
                end else begin
                    stallreq_o = 1'b1;
                    w_state_n  = REQ;
                end
            end
            REQ: begin
                stallreq_o = 1'b1;
                if (dbus.dbus_ack_i) w_state_n = DONE;
            end
            DONE: begin
                w_state_n = IDLE;
                if (w_load) begin
                    wb_wreg_en_o = mem_wreg_en_i & ~r_flushed;
                    wb_wdata_o   = w_load_val;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= 32'd0;
            r_be      <= 4'd0;
            r_wdata   <= 32'd0;
            r_rdata   <= 32'd0;
            r_flushed <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (r_state == IDLE && w_start) begin
                r_req   <= 1'b1;
                r_we    <= w_store;
                r_addr  <= {mem_ramaddr_i[31:2], 2'b00};
                r_be    <= w_be;
                r_wdata <= w_wdata;
            end
            if (r_state == REQ && dbus.dbus_ack_i) begin
                r_rdata <= dbus.dbus_rdata_i;
                r_req   <= 1'b0;
            end
            // A flush during REQ cannot abort the bus cycle; remember it
            if (r_state == REQ && flush_i) begin
                r_flushed <= 1'b1;
            end else if (r_state == DONE) begin
                r_flushed <= 1'b0;
            end
        end
    end

    assign dbus.dbus_req_o   = r_req;
    assign dbus.dbus_we_o    = r_we;
    assign dbus.dbus_addr_o  = r_addr;
    assign dbus.dbus_be_o    = r_be;
    assign dbus.dbus_wdata_o = r_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases then random
// transactions against an arithmetic reference model.
module tb_mem_stage;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_ramaddr_i;
    logic [31:0] mem_store_data_i;
    logic        mem_wreg_en_i;
    logic [4:0]  mem_wreg_addr_i;
    logic [31:0] mem_alu_i;
    logic        stallreq_o;
    logic        misalign_o;
    logic        wb_wreg_en_o;
    logic [4:0]  wb_wreg_addr_o;
    logic [31:0] wb_wdata_o;

    int checks = 0;
    int failures = 0;

    mem_stage_if bus ();

    mem_stage dut (
        .clk              (clk),
        .rst              (rst),
        .flush_i          (flush_i),
        .mem_op_i         (mem_op_i),
        .mem_ramaddr_i    (mem_ramaddr_i),
        .mem_store_data_i (mem_store_data_i),
        .mem_wreg_en_i    (mem_wreg_en_i),
        .mem_wreg_addr_i  (mem_wreg_addr_i),
        .mem_alu_i        (mem_alu_i),
        .dbus             (bus.master),
        .stallreq_o       (stallreq_o),
        .misalign_o       (misalign_o),
        .wb_wreg_en_o     (wb_wreg_en_o),
        .wb_wreg_addr_o   (wb_wreg_addr_o),
        .wb_wdata_o       (wb_wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: sizes in bytes, lanes by byte offset
    function automatic int nbytes(input logic [3:0] op);
        case (op)
            4'd1, 4'd2, 4'd6: return 1;
            4'd3, 4'd4, 4'd7: return 2;
            4'd5, 4'd8:       return 4;
            default:          return 0;
        endcase
    endfunction

    function automatic bit is_store(input logic [3:0] op);
        return op >= 4'd6 && op <= 4'd8;
    endfunction

    function automatic logic [31:0] lane_mask(input int n);
        logic [63:0] m;
        m = (64'd1 << (8 * n)) - 64'd1;
        return m[31:0];
    endfunction

    function automatic logic [3:0] model_be(input logic [3:0] op,
                                            input logic [31:0] a);
        logic [3:0] be;
        int off;
        be = 4'd0;
        off = int'(a % 4);
        for (int i = off; i < off + nbytes(op); i++)
            be = be | (4'd1 << (3 - i));
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [3:0] op,
                                                input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = nbytes(op);
        w = 32'd0;
        for (int k = 0; k < 4 / n; k++)
            w = w | ((d & lane_mask(n)) << (8 * n * k));
        return w;
    endfunction

    function automatic logic [31:0] model_load(input logic [3:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        int n;
        int off;
        n = nbytes(op);
        off = int'(a % 4);
        v = (rd >> (8 * (4 - off - n))) & lane_mask(n);
        if ((op == 4'd1 || op == 4'd3) && v[8*n-1])
            v = v | ~lane_mask(n);
        return v;
    endfunction

    task automatic set_none();
        mem_op_i = 4'd0;
        flush_i = 1'b0;
        bus.dbus_ack_i = 1'b0;
    endtask

    task automatic pass_step(input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] alu, input logic wen,
                             input logic [4:0] wa, input logic fl,
                             input logic stray_ack);
        tick();
        mem_op_i = op;
        mem_ramaddr_i = a;
        mem_alu_i = alu;
        mem_wreg_en_i = wen;
        mem_wreg_addr_i = wa;
        flush_i = fl;
        bus.dbus_ack_i = stray_ack;
        #1;
        chk("pass_wdata", wb_wdata_o, alu);
        chk("pass_waddr", {27'd0, wb_wreg_addr_o}, {27'd0, wa});
        chk("pass_wen", {31'd0, wb_wreg_en_o}, {31'd0, wen & ~fl});
        chk("pass_stall", {31'd0, stallreq_o}, 32'd0);
        chk("pass_req", {31'd0, bus.dbus_req_o}, 32'd0);
    endtask

    task automatic run_mem(input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] sd, input logic wen,
                           input logic [4:0] wa, input logic [31:0] rd,
                           input int ackd, input int flc);
        bit ld;
        bit aligned;
        bit flushed;
        ld = !is_store(op);
        aligned = (a % nbytes(op)) == 0;
        flushed = 1'b0;
        tick();
        mem_op_i = op;
        mem_ramaddr_i = a;
        mem_store_data_i = sd;
        mem_wreg_en_i = wen;
        mem_wreg_addr_i = wa;
        mem_alu_i = 32'hA5A5_0000 ^ a;
        flush_i = 1'b0;
        bus.dbus_ack_i = 1'b0;
        bus.dbus_rdata_i = ~rd;
        #1;
        chk("c0_misalign", {31'd0, misalign_o}, {31'd0, !aligned});
        chk("c0_stall", {31'd0, stallreq_o}, {31'd0, aligned});
        chk("c0_wen", {31'd0, wb_wreg_en_o}, 32'd0);
        chk("c0_req", {31'd0, bus.dbus_req_o}, 32'd0);
        if (!aligned) begin
            tick();
            set_none();
            #1;
            chk("mis_noreq", {31'd0, bus.dbus_req_o}, 32'd0);
            return;
        end
        for (int c = 1; c <= ackd; c++) begin
            tick();
            flush_i = (c == flc);
            if (c == flc) flushed = 1'b1;
            bus.dbus_ack_i = (c == ackd);
            bus.dbus_rdata_i = (c == ackd) ? rd : ~rd;
            #1;
            chk("req_req", {31'd0, bus.dbus_req_o}, 32'd1);
            chk("req_stall", {31'd0, stallreq_o}, 32'd1);
            chk("req_addr", bus.dbus_addr_o, a & 32'hFFFF_FFFC);
            chk("req_be", {28'd0, bus.dbus_be_o}, {28'd0, model_be(op, a)});
            chk("req_we", {31'd0, bus.dbus_we_o}, {31'd0, is_store(op)});
            if (!ld) chk("req_wdata", bus.dbus_wdata_o, model_wdata(op, sd));
        end
        tick();
        flush_i = 1'b0;
        bus.dbus_ack_i = 1'b0;
        bus.dbus_rdata_i = 32'h0BAD_0BAD;
        #1;
        chk("done_req", {31'd0, bus.dbus_req_o}, 32'd0);
        chk("done_stall", {31'd0, stallreq_o}, 32'd0);
        chk("done_wen", {31'd0, wb_wreg_en_o}, {31'd0, ld & wen & !flushed});
        chk("done_waddr", {27'd0, wb_wreg_addr_o}, {27'd0, wa});
        if (ld) chk("done_wdata", wb_wdata_o, model_load(op, a, rd));
    endtask

    initial begin
        rst = 1'b0;
        flush_i = 1'b0;
        mem_op_i = 4'd0;
        mem_ramaddr_i = 32'd0;
        mem_store_data_i = 32'd0;
        mem_wreg_en_i = 1'b0;
        mem_wreg_addr_i = 5'd0;
        mem_alu_i = 32'd0;
        bus.dbus_rdata_i = 32'd0;
        bus.dbus_ack_i = 1'b0;
        tick();
        chk("rst_req", {31'd0, bus.dbus_req_o}, 32'd0);
        chk("rst_addr", bus.dbus_addr_o, 32'd0);
        chk("rst_be", {28'd0, bus.dbus_be_o}, 32'd0);
        chk("rst_wdata", bus.dbus_wdata_o, 32'd0);
        chk("rst_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        rst = 1'b1;

        pass_step(4'd0, 32'd5, 32'h1234_5678, 1'b1, 5'd3, 1'b0, 1'b0);
        run_mem(4'd1, 32'h101, 32'd0, 1'b1, 5'd7, 32'h11F2_3344, 1, 0);
        run_mem(4'd2, 32'h101, 32'd0, 1'b1, 5'd7, 32'h11F2_3344, 1, 0);
        run_mem(4'd7, 32'h202, 32'hAAAA_BEEF, 1'b1, 5'd9, 32'd0, 4, 0);
        run_mem(4'd5, 32'h303, 32'd0, 1'b1, 5'd4, 32'd0, 1, 0);
        run_mem(4'd5, 32'h400, 32'd0, 1'b1, 5'd4, 32'hCAFE_F00D, 3, 2);
        run_mem(4'd5, 32'h404, 32'd0, 1'b1, 5'd4, 32'h8765_4321, 2, 0);
        run_mem(4'd3, 32'h502, 32'd0, 1'b1, 5'd6, 32'h1234_8001, 1, 0);

        // Flushed aligned op in IDLE issues nothing
        pass_step(4'd5, 32'h600, 32'h55, 1'b1, 5'd2, 1'b1, 1'b0);
        tick();
        set_none();
        #1;
        chk("idle_flush_noreq", {31'd0, bus.dbus_req_o}, 32'd0);

        // Asynchronous reset during REQ
        tick();
        mem_op_i = 4'd5;
        mem_ramaddr_i = 32'h700;
        mem_wreg_en_i = 1'b1;
        tick();
        chk("arst_pre_req", {31'd0, bus.dbus_req_o}, 32'd1);
        mem_op_i = 4'd0;
        mem_alu_i = 32'h0000_0777;
        rst = 1'b0;
        #1;
        chk("arst_req", {31'd0, bus.dbus_req_o}, 32'd0);
        chk("arst_addr", bus.dbus_addr_o, 32'd0);
        chk("arst_stall", {31'd0, stallreq_o}, 32'd0);
        tick();
        rst = 1'b1;
        pass_step(4'd0, 32'd0, 32'h0000_0888, 1'b1, 5'd1, 1'b0, 1'b1);
        pass_step(4'd0, 32'd0, 32'h0000_0999, 1'b1, 5'd1, 1'b0, 1'b0);

        for (int t = 0; t < 60; t++) begin
            logic [3:0] op;
            logic [31:0] a;
            int ackd;
            int flc;
            op = 4'($urandom_range(0, 15));
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00 | (a[1:0] & {2{op == 4'd1 || op == 4'd2 || op == 4'd6}});
            ackd = $urandom_range(1, 4);
            flc = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ackd) : 0;
            if (nbytes(op) == 0)
                pass_step(op, a, $urandom, 1'($urandom), 5'($urandom),
                          1'($urandom_range(0, 4) == 0), 1'($urandom));
            else
                run_mem(op, a, $urandom, 1'($urandom_range(0, 3) != 0),
                        5'($urandom), $urandom, ackd, flc);
        end

        tick();
        set_none();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
